// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_chain_loader
// Description : Loads the fabric configuration shift chain (ccff) from a
//               word-wide bitstream source.
//               - Each accepted word is serialized LSB-first onto the chain
//                 head, one bit per cycle.
//               - Shifted bits are counted up to CHAIN_LEN.
//               - The fabric's logic flip-flops are held in reset until the
//                 chain is fully loaded.
// Ports       :
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle pulse, starts a pass (honoured in IDLE/DONE)
//   in_valid      bitstream word valid
//   in_data       bitstream word, bit 0 shifted first
//   in_ready      loader accepts a word this cycle
//   ccff_head     serial data into the config-chain head
//   shift_en      chain shift enable; chain advances when 1
//   fabric_reset  high while the fabric must stay in reset
//   busy          configuration pass in progress
//   done          chain loaded; sticky until start/reset
//   bit_count     bits shifted in the current pass
//   parity_err    (CFG_PARITY_CHECK_EN only) parity check word mismatched
// Option      : `define CFG_PARITY_CHECK_EN adds a CHECK state that takes
//               one extra word whose bit 0 is the expected XOR of all chain
//               bits. On mismatch done still rises but fabric stays in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              fabric_reset,
    output logic              busy,
    output logic              done,
`ifdef CFG_PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic [CNT_W-1:0]  bit_count
);

    localparam int WCNT_W = $clog2(WORD_W);

    localparam logic [WCNT_W-1:0] C_WORD_LAST  = WCNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  C_CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef CFG_PARITY_CHECK_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    // Holds the not-yet-presented bits of the current word. Bit 0 of the
    // word goes straight to ccff_head on capture, so only WORD_W-1 remain.
    logic [WORD_W-2:0] r_sreg;
    logic [WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]  r_bit_count;

    logic r_in_ready, r_ccff_head, r_shift_en, r_fabric_reset, r_busy, r_done;
    logic w_in_ready_nxt, w_ccff_nxt, w_shift_en_nxt, w_fabric_reset_nxt;
    logic w_busy_nxt, w_done_nxt;
    logic w_word_end, w_chain_end;

`ifdef CFG_PARITY_CHECK_EN
    logic r_parity;
    logic r_parity_err;
    logic w_perr_nxt;
`endif

    assign w_word_end  = (r_wcnt == C_WORD_LAST);
    assign w_chain_end = (r_bit_count == C_CHAIN_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // in_ready is always 1 in LOAD, so in_valid alone completes
                // the handshake.
                if (in_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // The chain end wins over the word end: a partial last word
                // just stops being shifted.
                if (w_chain_end) begin
`ifdef CFG_PARITY_CHECK_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_DONE;
`endif
                end else if (w_word_end) begin
                    w_state_nxt = S_LOAD;
                end
            end
`ifdef CFG_PARITY_CHECK_EN
            S_CHECK: begin
                if (in_valid) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: outputs are registered from the next state so that
    // shift_en and ccff_head change on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready_nxt = (w_state_nxt == S_LOAD);
        w_shift_en_nxt = (w_state_nxt == S_SHIFT);
        w_busy_nxt     = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT);
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_ccff_nxt     = 1'b0;
        if (w_state_nxt == S_SHIFT) begin
            w_ccff_nxt = (r_state == S_LOAD) ? in_data[0] : r_sreg[0];
        end
`ifdef CFG_PARITY_CHECK_EN
        w_in_ready_nxt = w_in_ready_nxt || (w_state_nxt == S_CHECK);
        w_busy_nxt     = w_busy_nxt || (w_state_nxt == S_CHECK);
        w_perr_nxt     = r_parity_err;
        if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
            w_perr_nxt = 1'b0;
        end else if ((r_state == S_CHECK) && in_valid) begin
            w_perr_nxt = r_parity ^ in_data[0];
        end
        // A parity failure keeps the fabric in reset even after done.
        w_fabric_reset_nxt = !w_done_nxt || w_perr_nxt;
`else
        w_fabric_reset_nxt = !w_done_nxt;
`endif
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready     <= 1'b0;
            r_ccff_head    <= 1'b0;
            r_shift_en     <= 1'b0;
            r_fabric_reset <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
`ifdef CFG_PARITY_CHECK_EN
            r_parity_err   <= 1'b0;
`endif
        end else begin
            r_in_ready     <= w_in_ready_nxt;
            r_ccff_head    <= w_ccff_nxt;
            r_shift_en     <= w_shift_en_nxt;
            r_fabric_reset <= w_fabric_reset_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
`ifdef CFG_PARITY_CHECK_EN
            r_parity_err   <= w_perr_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, within-word counter, chain bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg      <= '0;
            r_wcnt      <= '0;
            r_bit_count <= '0;
`ifdef CFG_PARITY_CHECK_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_bit_count <= '0;
`ifdef CFG_PARITY_CHECK_EN
                        r_parity    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_sreg <= in_data[WORD_W-1:1];
                        r_wcnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // The bit on ccff_head is taken by the chain at this edge.
                    // bit_count cannot pass CHAIN_LEN because SHIFT is left
                    // on the edge that reaches it.
                    r_sreg      <= r_sreg >> 1;
                    r_wcnt      <= r_wcnt + WCNT_W'(1);
                    r_bit_count <= r_bit_count + CNT_W'(1);
`ifdef CFG_PARITY_CHECK_EN
                    r_parity    <= r_parity ^ r_ccff_head;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign ccff_head    = r_ccff_head;
    assign shift_en     = r_shift_en;
    assign fabric_reset = r_fabric_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bit_count    = r_bit_count;
`ifdef CFG_PARITY_CHECK_EN
    assign parity_err   = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_chain_loader
// Description : Self-checking bench for cfg_chain_loader. Random words are
//               turned into the expected serial chain image (LSB-first,
//               truncated to CHAIN_LEN) and every presented chain bit, the
//               bit counter and the completion flags are checked against it.
//               CHAIN_LEN is not a multiple of WORD_W so the last word is
//               partial.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_chain_loader;

    localparam int W      = 8;
    localparam int L      = 20;
    localparam int CW     = $clog2(L + 1);
    localparam int BUDGET = 2000;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          ccff_head;
    logic          shift_en;
    logic          fabric_reset;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;
`ifdef CFG_PARITY_CHECK_EN
    logic          parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cfg_chain_loader #(
        .WORD_W    (W),
        .CHAIN_LEN (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ccff_head    (ccff_head),
        .shift_en     (shift_en),
        .fabric_reset (fabric_reset),
        .busy         (busy),
        .done         (done),
`ifdef CFG_PARITY_CHECK_EN
        .parity_err   (parity_err),
`endif
        .bit_count    (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready,     0);
        check({tag, "_ccff"},      ccff_head,    0);
        check({tag, "_shift_en"},  shift_en,     0);
        check({tag, "_frst"},      fabric_reset, 1);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_done"},      done,         0);
        check({tag, "_bit_count"}, bit_count,    0);
`ifdef CFG_PARITY_CHECK_EN
        check({tag, "_perr"},      parity_err,   0);
`endif
    endtask

    // One configuration pass. gap_pct: chance in_valid is withheld per cycle;
    // stray_pct: chance of a (to-be-ignored) start pulse per cycle mid-pass;
    // bad_par: send a wrong parity check word (parity build only);
    // abort_at: apply reset when bit_count reaches this value (-1 = never).
    task automatic run_pass(input int gap_pct, input int stray_pct,
                            input bit bad_par, input int abort_at);
        int unsigned words[$];
        bit          exp_bits[$];
        int unsigned tmp;
        int          nwords, idx, wp, edges, exp_edges;
        bit          par, hs, done_seen, aborted;

        nwords = (L + W - 1) / W;
        for (int i = 0; i < nwords; i++) words.push_back($urandom_range(0, (1 << W) - 1));
        par = 1'b0;
        for (int b = 0; b < L; b++) begin
            tmp = words[b / W];
            exp_bits.push_back(tmp[b % W]);
            par = par ^ tmp[b % W];
        end
        exp_edges = nwords + L;
`ifdef CFG_PARITY_CHECK_EN
        words.push_back({31'd0, par ^ bad_par});
        exp_edges = exp_edges + 1;
`endif

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("st_busy", busy, 1);
        check("st_done", done, 0);
        check("st_frst", fabric_reset, 1);
        check("st_rdy",  in_ready, 1);
        check("st_bcnt", bit_count, 0);

        idx = 0; wp = 0; edges = 0; done_seen = 0; aborted = 0;
        while (!done_seen && !aborted && edges < BUDGET) begin
            in_valid = (wp < words.size()) && ($urandom_range(99) >= gap_pct);
            if (in_valid) in_data = W'(words[wp]);
            else          in_data = W'($urandom);
            start = ($urandom_range(99) < stray_pct);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            if (hs) wp++;
            check("busy_vs_done", busy, !done);
            check("rdy_excl", in_ready & shift_en, 0);
            check("bcnt", bit_count, idx);
            if (shift_en) begin
                if (idx < L) check("ccff", ccff_head, exp_bits[idx]);
                else         check("extra_shift", shift_en, 0);
                if (abort_at >= 0 && idx == abort_at) begin
                    reset = 1'b1;
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    check_reset_values("abort");
                    aborted = 1;
                end
                idx++;
            end
            if (done) done_seen = 1;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        if (!aborted) begin
            check("timeout", done_seen, 1);
            check("nbits", idx, L);
            check("fin_bcnt", bit_count, L);
            check("fin_busy", busy, 0);
            check("fin_rdy", in_ready, 0);
            check("fin_sen", shift_en, 0);
`ifdef CFG_PARITY_CHECK_EN
            check("fin_frst", fabric_reset, bad_par);
            check("fin_perr", parity_err, bad_par);
`else
            check("fin_frst", fabric_reset, 0);
`endif
            // With in_valid held high: one load cycle per word plus one
            // cycle per chain bit between the start edge and done.
            if (gap_pct == 0 && stray_pct == 0) check("latency", edges, exp_edges);
            // done and bit_count are held while idle in DONE.
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_done", done, 1);
            check("hold_bcnt", bit_count, L);
            check("hold_sen", shift_en, 0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Idle without start ignores in_valid.
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_reset_values("idle");

        run_pass(0, 0, 0, -1);    // full-rate load, latency check
        run_pass(40, 0, 0, -1);   // restart from DONE with backpressure
        run_pass(20, 15, 0, -1);  // stray starts mid-pass are ignored
        run_pass(0, 0, 0, 5);     // reset at bit_count 5
        run_pass(0, 0, 0, -1);    // clean reload from bit 0 after abort
        for (int k = 0; k < 4; k++) run_pass($urandom_range(0, 50), 5, 0, -1);
`ifdef CFG_PARITY_CHECK_EN
        run_pass(0, 0, 1, -1);    // wrong parity word: fabric stays in reset
        run_pass(10, 0, 0, -1);   // correct parity clears the error
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
